// File: rtl/dmi_dtm_ctrl.sv
// -----------------------------------------------------------------------------
// dmi_dtm_ctrl
//
// DTM-side DMI access controller. Turns JTAG `dmi` data-register Update-DR
// events into DMI requests, absorbs the matching responses, and keeps the
// sticky op status plus the captured read data for the next Capture-DR.
// The Capture/Update strobes are already synchronous to clk.
//
// Packed bus layouts:
//   dr_shift_i / dr_capture_o : {addr[6:0], data[31:0], op/status[1:0]}
//   dmi_req_o                 : {addr[6:0], op[1:0], data[31:0]}
//   dmi_resp_i                : {data[31:0], resp[1:0]}
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. While valid is high the payload stays stable. valid never
// depends combinationally on ready, and ready never depends on valid.
//
// Ports:
//   clk, rst_ni            clock, asynchronous active-low reset
//   dmi_select_i           IR selects the dmi register (qualifies strobes)
//   capture_dr_i           one-cycle Capture-DR strobe
//   update_dr_i            one-cycle Update-DR strobe
//   dr_shift_i             shifted-in DR value
//   dr_capture_o           value to load into the DR at capture
//   dmireset_i             clears the sticky status
//   dmihardreset_i         aborts the transaction and clears all state
//   dmi_clear_o            one-cycle flush pulse to downstream
//   dmi_req_o/_valid_o/_ready_i     request channel
//   dmi_resp_i/_valid_i/_ready_o    response channel
//   dbg_state_o            current FSM state (encoding below)
// -----------------------------------------------------------------------------
module dmi_dtm_ctrl #(
    parameter int unsigned RespTimeout = 0
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        dmi_select_i,
    input  logic        capture_dr_i,
    input  logic        update_dr_i,
    input  logic [40:0] dr_shift_i,
    output logic [40:0] dr_capture_o,
    input  logic        dmireset_i,
    input  logic        dmihardreset_i,
    output logic        dmi_clear_o,
    output logic [40:0] dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  logic [33:0] dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    output logic [2:0]  dbg_state_o
);

    // State encoding (also visible on dbg_state_o)
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_READ       = 3'd1;
    localparam logic [2:0] S_WAIT_READ  = 3'd2;
    localparam logic [2:0] S_WRITE      = 3'd3;
    localparam logic [2:0] S_WAIT_WRITE = 3'd4;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_FAILED = 2'd2;
    localparam logic [1:0] ERR_BUSY   = 2'd3;

    // Counter holds 0..RespTimeout; at least one bit even when disabled.
    localparam int unsigned CNT_W_RAW = $clog2(RespTimeout + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic        TO_EN     = (RespTimeout != 0);
    localparam int unsigned LAST_I    = (RespTimeout == 0) ? 0 : RespTimeout - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [6:0]       r_addr;
    logic [31:0]      r_data;
    logic [1:0]       r_error;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clear;

    logic [6:0]  w_shift_addr;
    logic [31:0] w_shift_data;
    logic [1:0]  w_shift_op;
    logic [31:0] w_resp_data;
    logic [1:0]  w_resp_code;

    logic       w_update;
    logic       w_capture;
    logic [1:0] w_err_eff;
    logic       w_idle;
    logic       w_in_req;
    logic       w_in_wait;
    logic       w_accept;
    logic       w_req_fire;
    logic       w_resp_fire;
    logic       w_timeout;
    logic [1:0] w_error_next;
    logic [1:0] w_req_op;

    assign w_shift_addr = dr_shift_i[40:34];
    assign w_shift_data = dr_shift_i[33:2];
    assign w_shift_op   = dr_shift_i[1:0];
    assign w_resp_data  = dmi_resp_i[33:2];
    assign w_resp_code  = dmi_resp_i[1:0];

    assign w_update  = dmi_select_i & update_dr_i;
    assign w_capture = dmi_select_i & capture_dr_i;

    // dmireset takes effect before a same-cycle update is judged.
    assign w_err_eff = dmireset_i ? ERR_OK : r_error;

    assign w_idle    = (r_state == S_IDLE);
    assign w_in_req  = (r_state == S_READ) || (r_state == S_WRITE);
    assign w_in_wait = (r_state == S_WAIT_READ) || (r_state == S_WAIT_WRITE);

    assign w_accept    = w_idle && w_update && (w_err_eff == ERR_OK);
    assign w_req_fire  = w_in_req && dmi_req_ready_i;
    assign w_resp_fire = w_in_wait && dmi_resp_valid_i;
    // A response in the final wait cycle wins over the timeout.
    assign w_timeout   = TO_EN && w_in_wait && !dmi_resp_valid_i && (r_cnt == CNT_LAST);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_shift_op == OP_READ) begin
                        w_state_next = S_READ;
                    end else if (w_shift_op == OP_WRITE) begin
                        w_state_next = S_WRITE;
                    end
                end
            end
            S_READ: begin
                if (dmi_req_ready_i) w_state_next = S_WAIT_READ;
            end
            S_WRITE: begin
                if (dmi_req_ready_i) w_state_next = S_WAIT_WRITE;
            end
            S_WAIT_READ, S_WAIT_WRITE: begin
                if (dmi_resp_valid_i || w_timeout) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (dmihardreset_i) w_state_next = S_IDLE;
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (decodes of state and registers only)
    // -------------------------------------------------------------------------
    always_comb begin
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        w_req_op         = 2'd0;
        case (r_state)
            S_READ: begin
                dmi_req_valid_o = 1'b1;
                w_req_op        = OP_READ;
            end
            S_WRITE: begin
                dmi_req_valid_o = 1'b1;
                w_req_op        = OP_WRITE;
            end
            S_WAIT_READ, S_WAIT_WRITE: begin
                dmi_resp_ready_o = 1'b1;
            end
            default: begin
                dmi_req_valid_o  = 1'b0;
                dmi_resp_ready_o = 1'b0;
            end
        endcase
    end

    assign dmi_req_o    = w_in_req ? {r_addr, w_req_op, r_data} : 41'd0;
    assign dr_capture_o = {r_addr, r_data, (w_idle ? r_error : ERR_BUSY)};
    assign dmi_clear_o  = r_clear;
    assign dbg_state_o  = r_state;

    // -------------------------------------------------------------------------
    // Sticky status: the first error wins until dmireset.
    // -------------------------------------------------------------------------
    always_comb begin
        w_error_next = w_err_eff;
        if (w_err_eff == ERR_OK) begin
            if (w_resp_fire && (w_resp_code != ERR_OK)) begin
                w_error_next = w_resp_code;
            end else if (w_timeout) begin
                w_error_next = ERR_FAILED;
            end else if (!w_idle && (w_update || w_capture)) begin
                w_error_next = ERR_BUSY;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= 7'd0;
            r_data  <= 32'd0;
            r_error <= ERR_OK;
            r_cnt   <= '0;
            r_clear <= 1'b0;
        end else if (dmihardreset_i) begin
            r_addr  <= 7'd0;
            r_data  <= 32'd0;
            r_error <= ERR_OK;
            r_cnt   <= '0;
            r_clear <= 1'b1;
        end else begin
            r_error <= w_error_next;
            r_clear <= w_timeout;

            // Any accepted update latches addr/data, including no-op ops.
            if (w_accept) begin
                r_addr <= w_shift_addr;
                r_data <= w_shift_data;
            end else if (w_resp_fire && (r_state == S_WAIT_READ)) begin
                r_data <= w_resp_data;
            end

            if (w_req_fire) begin
                r_cnt <= '0;
            end else if (TO_EN && w_in_wait && !dmi_resp_valid_i && !w_timeout) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmi_dtm_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for dmi_dtm_ctrl (RespTimeout = 4).
// Inputs change 1 ns after the rising edge; outputs are checked at the same
// point, after the edge has settled. A negedge monitor checks every request
// handshake against the expected request queue and counts clear pulses.
// -----------------------------------------------------------------------------
module tb_dmi_dtm_ctrl;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ      = 3'd1;
    localparam logic [2:0] S_WAIT_READ = 3'd2;

    logic        clk;
    logic        rst_ni;
    logic        dmi_select_i;
    logic        capture_dr_i;
    logic        update_dr_i;
    logic [40:0] dr_shift_i;
    logic [40:0] dr_capture_o;
    logic        dmireset_i;
    logic        dmihardreset_i;
    logic        dmi_clear_o;
    logic [40:0] dmi_req_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [33:0] dmi_resp_i;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [2:0]  dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;
    int req_cnt = 0;
    int clear_cnt = 0;
    logic [40:0] exp_q[$];

    dmi_dtm_ctrl #(.RespTimeout(4)) dut (
        .clk              (clk),
        .rst_ni           (rst_ni),
        .dmi_select_i     (dmi_select_i),
        .capture_dr_i     (capture_dr_i),
        .update_dr_i      (update_dr_i),
        .dr_shift_i       (dr_shift_i),
        .dr_capture_o     (dr_capture_o),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .dmi_clear_o      (dmi_clear_o),
        .dmi_req_o        (dmi_req_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_resp_i       (dmi_resp_i),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dbg_state_o      (dbg_state_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking task
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard / monitor
    always @(negedge clk) begin
        if (rst_ni && dmi_req_valid_o && dmi_req_ready_i) begin
            req_cnt++;
            if (exp_q.size() != 0) check("req_payload", dmi_req_o, exp_q.pop_front());
        end
        if (dmi_clear_o) clear_cnt++;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        dr_shift_i   = {a, d, op};
        dmi_select_i = 1'b1;
        update_dr_i  = 1'b1;
        tick();
        update_dr_i  = 1'b0;
    endtask

    task automatic do_capture();
        capture_dr_i = 1'b1;
        tick();
        capture_dr_i = 1'b0;
    endtask

    task automatic send_resp(input logic [31:0] d, input logic [1:0] r);
        dmi_resp_i       = {d, r};
        dmi_resp_valid_i = 1'b1;
        tick();
        dmi_resp_valid_i = 1'b0;
    endtask

    task automatic pulse_dmireset();
        dmireset_i = 1'b1;
        tick();
        dmireset_i = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Stimulus
    initial begin
        rst_ni           = 1'b0;
        dmi_select_i     = 1'b0;
        capture_dr_i     = 1'b0;
        update_dr_i      = 1'b0;
        dr_shift_i       = '0;
        dmireset_i       = 1'b0;
        dmihardreset_i   = 1'b0;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = '0;
        dmi_resp_valid_i = 1'b0;
        #2;
        check("rst_valid", dmi_req_valid_o, 1'b0);
        check("rst_rready", dmi_resp_ready_o, 1'b0);
        check("rst_clear", dmi_clear_o, 1'b0);
        check("rst_req", dmi_req_o, 41'd0);
        check("rst_capture", dr_capture_o, 41'd0);
        check("rst_state", dbg_state_o, S_IDLE);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Write, zero-wait downstream
        dmi_req_ready_i = 1'b1;
        exp_q.push_back({7'h10, 2'd2, 32'hDEADBEEF});
        do_update(7'h10, 32'hDEADBEEF, 2'd2);
        check("wr_valid", dmi_req_valid_o, 1'b1);
        check("wr_req", dmi_req_o, {7'h10, 2'd2, 32'hDEADBEEF});
        tick();
        check("wr_wait_rready", dmi_resp_ready_o, 1'b1);
        check("wr_wait_valid", dmi_req_valid_o, 1'b0);
        send_resp(32'h0, 2'd0);
        check("wr_idle", dbg_state_o, S_IDLE);
        check("wr_capture", dr_capture_o, {7'h10, 32'hDEADBEEF, 2'd0});
        check("wr_req_cnt", req_cnt, 1);

        // Read
        exp_q.push_back({7'h11, 2'd1, 32'h0});
        do_update(7'h11, 32'h0, 2'd1);
        tick();
        send_resp(32'h12345678, 2'd0);
        check("rd_capture", dr_capture_o, {7'h11, 32'h12345678, 2'd0});
        check("rd_rready", dmi_resp_ready_o, 1'b0);

        // Busy: request stalled, capture and second update while busy
        dmi_req_ready_i = 1'b0;
        exp_q.push_back({7'h20, 2'd1, 32'hAAAA5555});
        do_update(7'h20, 32'hAAAA5555, 2'd1);
        check("busy_status_decode", dr_capture_o[1:0], 2'd3);
        do_capture();
        do_update(7'h21, 32'h1, 2'd2);
        check("busy_state", dbg_state_o, S_READ);
        check("busy_req_stable", dmi_req_o, {7'h20, 2'd1, 32'hAAAA5555});
        dmi_req_ready_i = 1'b1;
        tick();
        check("busy_wait", dbg_state_o, S_WAIT_READ);
        send_resp(32'hCAFEF00D, 2'd0);
        check("busy_capture", dr_capture_o, {7'h20, 32'hCAFEF00D, 2'd3});
        do_update(7'h30, 32'h1234, 2'd1);
        check("busy_ignored_valid", dmi_req_valid_o, 1'b0);
        check("busy_ignored_capture", dr_capture_o, {7'h20, 32'hCAFEF00D, 2'd3});
        // dmireset in the same cycle as an update: update is accepted
        exp_q.push_back({7'h31, 2'd1, 32'h0});
        dmireset_i = 1'b1;
        do_update(7'h31, 32'h0, 2'd1);
        dmireset_i = 1'b0;
        check("rst_upd_valid", dmi_req_valid_o, 1'b1);
        tick();
        send_resp(32'h0BADC0DE, 2'd0);
        check("rst_upd_capture", dr_capture_o, {7'h31, 32'h0BADC0DE, 2'd0});
        check("busy_req_cnt", req_cnt, 4);

        // Failed op, then a stray response must not be consumed
        exp_q.push_back({7'h40, 2'd2, 32'h11112222});
        do_update(7'h40, 32'h11112222, 2'd2);
        tick();
        send_resp(32'h0, 2'd2);
        check("fail_capture", dr_capture_o, {7'h40, 32'h11112222, 2'd2});
        dmi_resp_i       = {32'h99999999, 2'd3};
        dmi_resp_valid_i = 1'b1;
        tick();
        check("stray_rready", dmi_resp_ready_o, 1'b0);
        dmi_resp_valid_i = 1'b0;
        check("stray_capture", dr_capture_o, {7'h40, 32'h11112222, 2'd2});
        do_update(7'h42, 32'h5, 2'd1);
        check("fail_ignored_valid", dmi_req_valid_o, 1'b0);
        pulse_dmireset();
        check("fail_cleared", dr_capture_o[1:0], 2'd0);

        // Busy set in flight stays over a later failing response
        exp_q.push_back({7'h41, 2'd1, 32'h0});
        do_update(7'h41, 32'h0, 2'd1);
        tick();
        do_capture();
        send_resp(32'h55, 2'd2);
        check("sticky_busy", dr_capture_o, {7'h41, 32'h00000055, 2'd3});
        pulse_dmireset();

        // Timeout: no response
        exp_q.push_back({7'h50, 2'd1, 32'h77777777});
        do_update(7'h50, 32'h77777777, 2'd1);
        tick();
        tick();
        tick();
        tick();
        check("to_still_wait", dbg_state_o, S_WAIT_READ);
        check("to_no_clear_yet", dmi_clear_o, 1'b0);
        tick();
        check("to_idle", dbg_state_o, S_IDLE);
        check("to_clear", dmi_clear_o, 1'b1);
        check("to_capture", dr_capture_o, {7'h50, 32'h77777777, 2'd2});
        tick();
        check("to_clear_one_cycle", dmi_clear_o, 1'b0);
        check("to_clear_cnt", clear_cnt, 1);
        pulse_dmireset();

        // Response on the 4th wait cycle beats the timeout
        exp_q.push_back({7'h51, 2'd1, 32'h0});
        do_update(7'h51, 32'h0, 2'd1);
        tick();
        tick();
        tick();
        tick();
        send_resp(32'h13572468, 2'd0);
        check("late_ok_capture", dr_capture_o, {7'h51, 32'h13572468, 2'd0});
        check("late_ok_clear", dmi_clear_o, 1'b0);

        // Hard reset in WAIT_READ
        exp_q.push_back({7'h60, 2'd1, 32'h0});
        do_update(7'h60, 32'h0, 2'd1);
        tick();
        check("hr_wait_rready", dmi_resp_ready_o, 1'b1);
        dmihardreset_i = 1'b1;
        tick();
        dmihardreset_i = 1'b0;
        check("hr_state", dbg_state_o, S_IDLE);
        check("hr_clear", dmi_clear_o, 1'b1);
        check("hr_rready", dmi_resp_ready_o, 1'b0);
        check("hr_capture", dr_capture_o, 41'd0);
        dmi_resp_i       = {32'hFFFF0000, 2'd0};
        dmi_resp_valid_i = 1'b1;
        tick();
        check("hr_late_rready", dmi_resp_ready_o, 1'b0);
        check("hr_late_capture", dr_capture_o, 41'd0);
        check("hr_clear_done", dmi_clear_o, 1'b0);
        dmi_resp_valid_i = 1'b0;
        check("hr_clear_cnt", clear_cnt, 2);

        // Asynchronous reset mid-transaction
        dmi_req_ready_i = 1'b0;
        do_update(7'h70, 32'hABCDEF01, 2'd2);
        check("ar_pre_valid", dmi_req_valid_o, 1'b1);
        #3;
        rst_ni = 1'b0;
        #1;
        check("ar_valid", dmi_req_valid_o, 1'b0);
        check("ar_state", dbg_state_o, S_IDLE);
        check("ar_capture", dr_capture_o, 41'd0);
        check("ar_clear", dmi_clear_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        check("ar_clear_cnt", clear_cnt, 2);
        check("final_req_cnt", req_cnt, 9);
        check("final_exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmi_dtm_ctrl.md
# dmi_dtm_ctrl

- Clock-domain-internal DMI access controller on the DTM side of the debug transport.
- Turns JTAG `dmi` data-register update/capture events into `dm::dmi_req_t` transactions and absorbs the matching `dm::dmi_resp_t`.
- Maintains the sticky DMI op status and the captured read data; drives the `cdc_stage` request/response input side directly.
- Capture/update strobes arrive already synchronised to `clk`.

## Interface
- `RespTimeout`, default 0: maximum cycles spent waiting for a response. 0 disables the timeout.
- `clk` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `dmi_select_i` in 1: JTAG IR currently selects the `dmi` register.
- `capture_dr_i` in 1: one-cycle Capture-DR strobe.
- `update_dr_i` in 1: one-cycle Update-DR strobe.
- `dr_shift_i` in 41: shifted-in value, `{addr[6:0], data[31:0], op[1:0]}`.
- `dr_capture_o` out 41: value loaded at capture, `{addr_q, data_q, status}`.
- `dmireset_i` in 1: one-cycle strobe that clears the sticky status.
- `dmihardreset_i` in 1: one-cycle strobe that aborts the transaction and clears all state.
- `dmi_clear_o` out 1: one-cycle flush pulse to downstream.
- `dmi_req_o` out `dm::dmi_req_t`: request (`addr`, `op`, `data`).
- `dmi_req_valid_o` out 1: request valid.
- `dmi_req_ready_i` in 1: request ready.
- `dmi_resp_i` in `dm::dmi_resp_t`: response (`data`, `resp`).
- `dmi_resp_valid_i` in 1: response valid.
- `dmi_resp_ready_o` out 1: response ready.

## Operation
- States:
  - IDLE
  - READ: issuing a read request.
  - WAIT_READ: read request accepted, waiting for its response.
  - WRITE: issuing a write request.
  - WAIT_WRITE: write request accepted, waiting for its response.
- Registers:
  - `addr_q[6:0]` and `data_q[31:0]` hold the current transaction.
  - `error_q[1:0]` is the sticky status: 0 = ok, 2 = op failed, 3 = busy.
  - A timeout counter wide enough to reach `RespTimeout`.
- Events below are qualified by `dmi_select_i`, except `dmireset_i` and `dmihardreset_i`.
- Update while in IDLE with `error_q == 0`:
  - `addr_q` and `data_q` load from `dr_shift_i`.
  - op 1 (read) → READ.
  - op 2 (write) → WRITE.
  - op 0 or op 3 → stay in IDLE, no request.
- Update while in IDLE with `error_q != 0`: ignored, no request, nothing is latched.
- Update in any non-IDLE state: `error_q <= 3` only if `error_q == 0`. The request is dropped and the in-flight transaction continues.
- Capture in any non-IDLE state: `error_q <= 3` only if `error_q == 0`.
- `dr_capture_o` status field:
  - 3 when the state is not IDLE.
  - Otherwise `error_q`.
- READ/WRITE:
  - `dmi_req_valid_o = 1`, `dmi_req_o = {addr_q, op, data_q}`, held stable until the handshake.
  - On `valid & ready`, move to WAIT_READ or WAIT_WRITE and zero the timeout counter.
- WAIT_READ/WAIT_WRITE: `dmi_resp_ready_o = 1`. On `dmi_resp_valid_i`:
  - WAIT_READ only: `data_q <= dmi_resp_i.data`.
  - If `dmi_resp_i.resp != 0` and `error_q == 0`: `error_q <= dmi_resp_i.resp`.
  - Next state is IDLE.
- Timeout, when `RespTimeout != 0`:
  - The counter increments each WAIT cycle without a response.
  - On the cycle the counter reaches `RespTimeout` with no response: `error_q <= 2` (if 0), go to IDLE, pulse `dmi_clear_o`. `data_q` is unchanged.
  - A response arriving in that same cycle wins over the timeout.
- `dmi_resp_ready_o` is 0 outside the WAIT states, so stray responses are not consumed.
- `dmireset_i`: `error_q <= 0`. An update in the same cycle is evaluated with `error_q` taken as 0.
- `dmihardreset_i` has priority over every other event:
  - state → IDLE; `error_q`, counter, `addr_q`, `data_q` → 0.
  - `dmi_clear_o` pulses for 1 cycle.
  - Any in-flight request or response is abandoned.
- `dmi_clear_o` is high exactly one cycle per hard reset or timeout, never otherwise.

## Timing
- Reset values:
  - IDLE; `error_q` = 0, `addr_q` = 0, `data_q` = 0.
  - `dmi_req_valid_o`, `dmi_resp_ready_o`, `dmi_clear_o` = 0.
  - `dmi_req_o` = all zeros; `dr_capture_o` = all zeros.
- All outputs are registered state or decodes of state/registers. No combinational path from any input to `dmi_req_valid_o` or `dmi_resp_ready_o`.
- An update in cycle N drives `dmi_req_valid_o` high from N+1.
- A request handshake at edge E moves to WAIT from E.
- A response accepted at edge E: IDLE and the new `data_q` are visible after E.
- With a zero-wait downstream (ready held high, response returned 1 cycle after the request handshake): update → IDLE in 3 cycles.
- Reset asserted mid-transaction: everything returns to reset values immediately, asynchronously, with no `dmi_clear_o` pulse.

## Test plan
- Write: update `{0x10, 0xDEADBEEF, 2}`, ready high, resp `{0, 0}` one cycle later → one request `{0x10, WRITE, 0xDEADBEEF}`, back to IDLE, capture status 0.
- Read: update `{0x11, 0, 1}`, resp `{0x12345678, 0}` → `data_q = 0x12345678`, `dr_capture_o = {0x11, 0x12345678, 0}`.
- Busy:
  - Hold `dmi_req_ready_i` low and issue a capture plus a second update → status 3 and the second request is never issued.
  - Further updates are ignored until `dmireset_i`; then a new read is accepted.
- Failed op: response resp = 2 → `error_q = 2`. It stays 2 when a later response returns 3 while the error is still uncleared.
- Timeout, `RespTimeout = 4`:
  - No response → `error_q = 2` and one `dmi_clear_o` pulse.
  - A response arriving on the 4th WAIT cycle instead → no error.
- Hard reset in WAIT_READ → IDLE, `dmi_clear_o` pulse, `dmi_resp_ready_o` low the next cycle, a late response is not consumed.
